// File: rtl/core_bus_responder_if.sv
// Core cache bus between a core-side initiator (master) and a responder (slave).
// Carries the request beat handshake and the held-until-acknowledged response.
interface core_bus_responder_if #(
  parameter int TAG_WIDTH = 13
) ();

  logic                 reqcyc;
  logic [63:0]          req;
  logic [TAG_WIDTH-1:0] reqtag;
  logic                 reqack;
  logic                 respcyc;
  logic [63:0]          resp;
  logic [TAG_WIDTH-1:0] resptag;
  logic                 respack;

  modport master (
    output reqcyc, req, reqtag, respack,
    input  reqack, respcyc, resp, resptag
  );

  modport slave (
    input  reqcyc, req, reqtag, respack,
    output reqack, respcyc, resp, resptag
  );

endinterface

// File: rtl/core_bus_responder.sv
// Memory-stage responder of the core cache bus: serves reads/writes from a local
// word array after a fixed latency. Define CORE_BUS_RESPONDER_RANGE_CHECK_EN to reject out-of-range addresses.
module core_bus_responder #(
  parameter int WORDS     = 256,
  parameter int LATENCY   = 2,
  parameter int TAG_WIDTH = 13
) (
  input  logic                 clk,
  input  logic                 reset,
  core_bus_responder_if.slave  bus
);

  localparam int          ADDR_BITS  = $clog2(WORDS);
  localparam logic [3:0]  LAT_LOAD   = 4'(LATENCY - 1);
  localparam logic [63:0] OOR_DATA   = 64'hDEADBEEF_DEADBEEF;

  generate
    if (LATENCY < 1 || LATENCY > 15) begin : gBadLatency
      $error("core_bus_responder: LATENCY must be in 1..15");
    end
    if ((1 << ADDR_BITS) != WORDS) begin : gBadWords
      $error("core_bus_responder: WORDS must be a power of two");
    end
  endgenerate

  typedef enum logic [2:0] {
    StIdle,
    StAddrAck,
    StWaitData,
    StDataAck,
    StLatency,
    StResp
  } state_t;

  state_t                 state;
  logic [ADDR_BITS-1:0]   addrIdx;
  logic [TAG_WIDTH-1:0]   tagReg;
  logic                   outOfRange;
  logic [63:0]            respData;
  logic [3:0]             latCount;
  logic [63:0]            mem [WORDS];

  logic                   reqOutOfRange;
  logic                   memWe;

`ifdef CORE_BUS_RESPONDER_RANGE_CHECK_EN
  assign reqOutOfRange = |bus.req[63:ADDR_BITS+3];
`else
  // Upper address bits simply wrap onto the array.
  assign reqOutOfRange = 1'b0;
`endif

  assign memWe = (state == StWaitData) && bus.reqcyc && !outOfRange;

  // NOTE: the backing array has no reset; its contents must survive a mid-transaction reset.
  always_ff @(posedge clk) begin
    if (memWe) mem[addrIdx] <= bus.req;
  end

  // NOTE: every register here uses <= so all next-state values come from pre-edge state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= StIdle;
      addrIdx     <= '0;
      tagReg      <= '0;
      outOfRange  <= 1'b0;
      respData    <= '0;
      latCount    <= '0;
      bus.reqack  <= 1'b0;
      bus.respcyc <= 1'b0;
      bus.resp    <= '0;
      bus.resptag <= '0;
    end else begin
      case (state)
        StIdle: begin
          if (bus.reqcyc) begin
            addrIdx    <= bus.req[ADDR_BITS+2:3];
            tagReg     <= bus.reqtag;
            outOfRange <= reqOutOfRange;
            bus.reqack <= 1'b1;
            state      <= StAddrAck;
          end
        end

        StAddrAck: begin
          bus.reqack <= 1'b0;
          if (tagReg[TAG_WIDTH-1]) begin
            state <= StWaitData;
          end else begin
            respData <= outOfRange ? OOR_DATA : mem[addrIdx];
            latCount <= LAT_LOAD;
            state    <= StLatency;
          end
        end

        StWaitData: begin
          if (bus.reqcyc) begin
            respData   <= outOfRange ? OOR_DATA : bus.req;
            bus.reqack <= 1'b1;
            state      <= StDataAck;
          end
        end

        StDataAck: begin
          bus.reqack <= 1'b0;
          latCount   <= LAT_LOAD;
          state      <= StLatency;
        end

        StLatency: begin
          if (latCount == 4'd0) begin
            bus.respcyc <= 1'b1;
            bus.resp    <= respData;
            bus.resptag <= tagReg;
            state       <= StResp;
          end else begin
            latCount <= latCount - 4'd1;
          end
        end

        StResp: begin
          if (bus.respack) begin
            bus.respcyc <= 1'b0;
            state       <= StIdle;
          end
        end

        default: state <= StIdle;
      endcase
    end
  end

  // Protocol properties: single-cycle accept pulses and a stable held response.
  assert property (@(posedge clk) disable iff (!reset) bus.reqack |=> !bus.reqack);

  assert property (@(posedge clk) disable iff (!reset)
    (bus.respcyc && !bus.respack) |=> (bus.respcyc && $stable(bus.resp) && $stable(bus.resptag)));

endmodule

// File: tb/tb_core_bus_responder.sv
// Randomized self-checking bench for core_bus_responder against an array-based
// reference model of the bus rules (timing, wrap/range, stalls, reset).
module tb_core_bus_responder;

  localparam int          WORDS   = 256;
  localparam int          LAT     = 2;
  localparam int          TW      = 13;
  localparam logic [63:0] PATTERN = 64'hDEADBEEF_DEADBEEF;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  core_bus_responder_if #(.TAG_WIDTH(TW)) bus ();

  core_bus_responder #(
    .WORDS(WORDS), .LATENCY(LAT), .TAG_WIDTH(TW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int nCompared   = 0;
  int nMismatched = 0;

  logic [63:0] refMem [WORDS];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit refOutOfRange(input logic [63:0] addr);
`ifdef CORE_BUS_RESPONDER_RANGE_CHECK_EN
    return addr >= 64'(WORDS * 8);
`else
    return 1'b0;
`endif
  endfunction

  function automatic int refIndex(input logic [63:0] addr);
    return int'((addr / 64'd8) % 64'(WORDS));
  endfunction

  function automatic logic [63:0] refRead(input logic [63:0] addr);
    if (refOutOfRange(addr)) return PATTERN;
    return refMem[refIndex(addr)];
  endfunction

  function automatic logic [63:0] refWrite(input logic [63:0] addr, input logic [63:0] data);
    if (refOutOfRange(addr)) return PATTERN;
    refMem[refIndex(addr)] = data;
    return data;
  endfunction

  task automatic waitEdge();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [TW-1:0] makeTag(input bit isWrite);
    logic [TW-1:0] t;
    t[TW-2:0] = (TW-1)'($urandom);
    t[TW-1]   = isWrite;
    return t;
  endfunction

  // One complete transaction from IDLE, checking every timing point along the way.
  task automatic runTxn(input bit isWrite, input logic [63:0] addr, input logic [63:0] wdata,
                        input int gap, input bit holdThrough, input int stall, input bit keepAck);
    logic [TW-1:0] tag;
    logic [63:0]   expData;
    int            n;
    tag = makeTag(isWrite);
    expData = isWrite ? refWrite(addr, wdata) : refRead(addr);

    @(negedge clk);
    bus.reqcyc = 1'b1;
    bus.req    = addr;
    bus.reqtag = tag;
    n = 0;
    do begin waitEdge(); n++; end while (!bus.reqack && n < 50);
    check("addrAckEdges", 64'(n), 64'd1);

    if (isWrite) begin
      @(negedge clk);
      bus.req    = wdata;
      bus.reqcyc = holdThrough;
      waitEdge();
      check("addrAckPulse", 64'(bus.reqack), 64'd0);
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        bus.reqcyc = 1'b0;
        waitEdge();
        check("noAckWithoutBeat", 64'(bus.reqack), 64'd0);
      end
      @(negedge clk);
      bus.reqcyc = 1'b1;
      waitEdge();
      check("dataAck", 64'(bus.reqack), 64'd1);
    end

    @(negedge clk);
    bus.reqcyc = 1'b0;
    n = 0;
    do begin
      waitEdge();
      n++;
      if (n == 1) check("ackPulse", 64'(bus.reqack), 64'd0);
    end while (!bus.respcyc && n < 50);
    check("respLatency", 64'(n), 64'(LAT + 1));
    check("respData", bus.resp, expData);
    check("respTag", 64'(bus.resptag), 64'(tag));

    if (bus.respack) begin
      waitEdge();
      check("staleAckCompletesAfterOne", 64'(bus.respcyc), 64'd0);
    end else begin
      for (int s = 0; s < stall; s++) begin
        waitEdge();
        check("stallRespcyc", 64'(bus.respcyc), 64'd1);
        check("stallResp", bus.resp, expData);
      end
      @(negedge clk);
      bus.respack = 1'b1;
      waitEdge();
      check("respcycFall", 64'(bus.respcyc), 64'd0);
    end
    @(negedge clk);
    bus.respack = keepAck;
  endtask

  logic [63:0]   addr, wdata;
  logic [TW-1:0] tagA, tagB;
  int            idx, hiWrap, gap, stall, n;
  bit            isWrite, hold, keep, sawAck;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset       = 1'b0;
    bus.reqcyc  = 1'b0;
    bus.req     = '0;
    bus.reqtag  = '0;
    bus.respack = 1'b0;

    // Reset then idle.
    repeat (3) @(posedge clk);
    #1;
    check("rstReqack", 64'(bus.reqack), 64'd0);
    check("rstRespcyc", 64'(bus.respcyc), 64'd0);
    check("rstResp", bus.resp, 64'd0);
    check("rstResptag", 64'(bus.resptag), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      waitEdge();
      check("idleCtl", {62'd0, bus.reqack, bus.respcyc}, 64'd0);
      check("idleData", bus.resp | 64'(bus.resptag), 64'd0);
    end

    // Prime the low part of the array so every later read has a known value.
    for (int i = 0; i < 16; i++)
      runTxn(1'b1, 64'(i * 8), {$urandom, $urandom}, 0, 1'b0, 0, 1'b0);

    // Write then read 0x40.
    runTxn(1'b1, 64'h40, 64'h1122334455667788, 1, 1'b0, 0, 1'b0);
    runTxn(1'b0, 64'h40, 64'd0, 0, 1'b0, 0, 1'b0);

    // Stalled ack for 20 cycles, then stale-high respack on the next response.
    runTxn(1'b0, 64'h40, 64'd0, 0, 1'b0, 20, 1'b1);
    runTxn(1'b0, 64'h18, 64'd0, 0, 1'b0, 0, 1'b0);

    // Wrap / range behaviour at WORDS*8.
    runTxn(1'b1, 64'h0, 64'hAA, 0, 1'b1, 0, 1'b0);
    runTxn(1'b0, 64'h800, 64'd0, 0, 1'b0, 0, 1'b0);
    runTxn(1'b1, 64'h800, 64'h5555, 2, 1'b0, 0, 1'b0);
    runTxn(1'b0, 64'h0, 64'd0, 0, 1'b0, 0, 1'b0);

    // Busy request: second READ held high from LATENCY through RESP.
    tagA = makeTag(1'b0);
    tagB = makeTag(1'b0);
    @(negedge clk);
    bus.reqcyc = 1'b1;
    bus.req    = 64'h40;
    bus.reqtag = tagA;
    waitEdge();
    check("busyFirstAck", 64'(bus.reqack), 64'd1);
    @(negedge clk);
    bus.req    = 64'h48;
    bus.reqtag = tagB;
    sawAck = 1'b0;
    n = 0;
    do begin waitEdge(); n++; if (bus.reqack) sawAck = 1'b1; end while (!bus.respcyc && n < 50);
    check("busyLatency", 64'(n), 64'(LAT + 1));
    check("busyFirstData", bus.resp, refRead(64'h40));
    check("busyFirstTag", 64'(bus.resptag), 64'(tagA));
    repeat (3) begin waitEdge(); if (bus.reqack) sawAck = 1'b1; end
    check("busyNoAck", 64'(sawAck), 64'd0);
    @(negedge clk);
    bus.respack = 1'b1;
    waitEdge();
    check("busyFall", 64'(bus.respcyc), 64'd0);
    check("busyNoAckOnFall", 64'(bus.reqack), 64'd0);
    @(negedge clk);
    bus.respack = 1'b0;
    waitEdge();
    check("busySecondAck", 64'(bus.reqack), 64'd1);
    @(negedge clk);
    bus.reqcyc = 1'b0;
    n = 0;
    do begin waitEdge(); n++; end while (!bus.respcyc && n < 50);
    check("busySecondLatency", 64'(n), 64'(LAT + 1));
    check("busySecondData", bus.resp, refRead(64'h48));
    check("busySecondTag", 64'(bus.resptag), 64'(tagB));
    @(negedge clk);
    bus.respack = 1'b1;
    waitEdge();
    check("busySecondFall", 64'(bus.respcyc), 64'd0);
    @(negedge clk);
    bus.respack = 1'b0;

    // Reset while waiting for the data beat of a write to 0x40.
    bus.reqcyc = 1'b1;
    bus.req    = 64'h40;
    bus.reqtag = makeTag(1'b1);
    waitEdge();
    check("rstWriteAddrAck", 64'(bus.reqack), 64'd1);
    @(negedge clk);
    bus.reqcyc = 1'b0;
    bus.req    = 64'hFFFF_0000_FFFF_0000;
    repeat (2) waitEdge();
    #2;
    reset = 1'b0;
    #1;
    check("midRstReqack", 64'(bus.reqack), 64'd0);
    check("midRstRespcyc", 64'(bus.respcyc), 64'd0);
    check("midRstResp", bus.resp, 64'd0);
    check("midRstResptag", 64'(bus.resptag), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    runTxn(1'b0, 64'h40, 64'd0, 0, 1'b0, 0, 1'b0);

    // Randomized traffic, including aliased/out-of-range addresses.
    for (int i = 0; i < 60; i++) begin
      idx     = $urandom_range(0, 15);
      hiWrap  = ($urandom_range(0, 3) == 0) ? 1 : 0;
      addr    = 64'((idx + hiWrap * WORDS) * 8 + $urandom_range(0, 7));
      isWrite = 1'($urandom_range(0, 1));
      wdata   = {$urandom, $urandom};
      gap     = $urandom_range(0, 3);
      hold    = 1'($urandom_range(0, 1));
      stall   = $urandom_range(0, 4);
      keep    = ($urandom_range(0, 3) == 0);
      runTxn(isWrite, addr, wdata, gap, hold, stall, keep);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
